multdiv: RTL and testbench

Iterative signed 32-bit multiply/divide unit that sits in the execute stage beside the ALU. It takes the same operand pair from the ID/EX latch and feeds the writeback mux. Any operation launches on a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse and completes with a one-cycle `data_resultRDY` pulse. The pipeline stalls on `data_busy`.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_div_step.sv | 32 +++
 rtl/multdiv.sv | 169 ++++++++++++++++
 tb/tb_multdiv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int          ITER    = 32;
  localparam int          CNT_W   = 6;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the remainder, subtract the divisor if it fits, record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sh   = {rem_i, quo_i[WIDTH-1]};
    fits = (sh >= {1'b0, div_i});
    // When the divisor fits, the true difference is below the divisor, so the
    // truncated subtraction is exact.
    diff = sh[WIDTH-1:0] - div_i;
    if (fits) begin
      rem_o = diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Optional MULTDIV_EARLY_DIV0_EN: divide-by-zero completes after one cycle.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = multdiv_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;       // multiplicand, or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;     // Booth high word, or remainder
  logic [WIDTH-1:0]   lo_q, lo_d;     // Booth low word, or dividend/quotient
  logic               qm1_q, qm1_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [WIDTH:0]     hi_ext, a_ext, booth_sum;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               early_dz;

`ifdef MULTDIV_EARLY_DIV0_EN
  assign early_dz = dz_q;
`else
  assign early_dz = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (hi_q),
    .quo_i (lo_q),
    .div_i (a_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  // Sign-extend to 33 bits so hi +/- A never overflows before the shift.
  always_comb begin
    hi_ext = {hi_q[WIDTH-1], hi_q};
    a_ext  = {a_q[WIDTH-1], a_q};
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_ext + a_ext;
      2'b10:   booth_sum = hi_ext - a_ext;
      default: booth_sum = hi_ext;
    endcase
  end

  assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;

    case (state_q)
      MUL: begin
        if (cnt_q == ITER_CNT) begin
          result_d = lo_q;
          exc_d    = (hi_q != {WIDTH{lo_q[WIDTH-1]}});
          state_d  = DONE;
        end else begin
          hi_d  = booth_sum[WIDTH:1];
          lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
          qm1_d = lo_q[0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        if (cnt_q == ITER_CNT || early_dz) begin
          if (dz_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? (~lo_q + 1'b1) : lo_q;
            exc_d    = ovf_q;
          end
          state_d = DONE;
        end else begin
          hi_d  = rem_nxt;
          lo_d  = quo_nxt;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A new start overrides whatever is in flight; the aborted op never strobes.
    if (ctrl_MULT) begin
      state_d = MUL;
      cnt_d   = '0;
      a_d     = data_operandA;
      hi_d    = '0;
      lo_d    = data_operandB;
      qm1_d   = 1'b0;
      dz_d    = 1'b0;
    end else if (ctrl_DIV) begin
      state_d = DIV;
      cnt_d   = '0;
      a_d     = mag_b;
      hi_d    = '0;
      lo_d    = mag_a;
      qm1_d   = 1'b0;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d    = (data_operandB == '0);
      ovf_d   = (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign data_busy      = (state_q == MUL) || ((state_q == DIV) && !early_dz);

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv with hand-computed results.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, data_busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULTDIV_EARLY_DIV0_EN
  localparam int DZ_LAT  = 1;
  localparam int DZ_BUSY = 0;
`else
  localparam int DZ_LAT  = 33;
  localparam int DZ_BUSY = 33;
`endif

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called around a negedge; the start is sampled on the following posedge (E0).
  task automatic start_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = !mul;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Returns at the negedge of the DONE cycle.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input logic [31:0] exp_res, input logic exp_exc);
    int k  = 0;
    int bc = 0;
    bit seen = 0;
    while (k <= 100) begin
      @(negedge clock);
      if (data_busy) bc++;
      if (data_resultRDY) begin
        seen = 1;
        break;
      end
      @(posedge clock);
      #1;
      k++;
    end
    check({tag, "_lat"},  seen ? k : -1, exp_lat);
    check({tag, "_busy"}, bc, exp_busy);
    check({tag, "_res"},  data_result, exp_res);
    check({tag, "_exc"},  {31'd0, data_exception}, {31'd0, exp_exc});
  endtask

  task automatic check_rdy_drops(input string tag);
    @(negedge clock);
    check({tag, "_rdy_low"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int strobes;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    check("rst_res", data_result, 32'd0);
    check("rst_flags", {29'd0, data_exception, data_resultRDY, data_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 7 * -6 = -42
    start_op(1, 32'd7, 32'hFFFF_FFFA);
    wait_done("mul_7x-6", 33, 33, 32'hFFFF_FFD6, 1'b0);
    check_rdy_drops("mul_7x-6");

    // 2^16 * 2^16 = 2^32: low word 0, overflow
    start_op(1, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul_ovf", 33, 33, 32'h0000_0000, 1'b1);
    check_rdy_drops("mul_ovf");

    // INT_MIN * -1 = +2^31 does not fit
    start_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("mul_min_neg1", 33, 33, 32'h8000_0000, 1'b1);

    // Start on the DONE cycle: INT_MIN * INT_MIN = 2^62
    start_op(1, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul_chain", 33, 33, 32'h0000_0000, 1'b1);
    check_rdy_drops("mul_chain");

    // -7 / 2 = -3 (truncate toward zero)
    start_op(0, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_-7/2", 33, 33, 32'hFFFF_FFFD, 1'b0);
    check_rdy_drops("div_-7/2");

    // -100 / -7 = 14
    start_op(0, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_done("div_neg_neg", 33, 33, 32'd14, 1'b0);
    check_rdy_drops("div_neg_neg");

    // INT_MIN / -1 overflow
    start_op(0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_neg1", 33, 33, 32'h8000_0000, 1'b1);
    check_rdy_drops("div_min_neg1");

    // Divide by zero
    start_op(0, 32'd5, 32'd0);
    wait_done("div_zero", DZ_LAT, DZ_BUSY, 32'd0, 1'b1);
    check_rdy_drops("div_zero");

    // Abort: MULT at E0, DIV 100/7 at E10
    start_op(1, 32'd123, 32'd456);
    strobes = 0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) strobes++;
    end
    start_op(0, 32'd100, 32'd7);
    wait_done("abort_div", 33, 33, 32'd14, 1'b0);
    check("abort_early_strobes", strobes, 0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) strobes++;
    end
    check("abort_late_strobes", strobes, 0);

    // Reset mid-operation
    start_op(0, 32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_res", data_result, 32'd0);
    check("midrst_flags", {29'd0, data_exception, data_resultRDY, data_busy}, 32'd0);
    #3 reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY || data_busy) strobes++;
    end
    check("midrst_quiet", strobes, 0);
    start_op(1, 32'd3, 32'd4);
    wait_done("mul_3x4", 33, 33, 32'd12, 1'b0);
    check_rdy_drops("mul_3x4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
